// File: rtl/aes_pkg.sv
// Shared AES definitions for the column datapath: GF(2^8) helpers, the round
// constant and the mix/add-key FSM state type.
package aes_pkg;

   localparam logic [7:0] AES_POLY      = 8'h1B;
   localparam logic [3:0] AES_FINAL_RND = 4'd14;

   typedef enum logic {
      IDLE,
      CALC
   } mix_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction

   // Byte 0 of a column is the most significant byte (row 0).
   function automatic logic [7:0] colByte(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      unique case (idx)
         2'd0:    b = w[31:24];
         2'd1:    b = w[23:16];
         2'd2:    b = w[15:8];
         default: b = w[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mix_byte.sv
// One output byte of MixColumns + AddRoundKey: 2*a0 ^ 3*a1 ^ a2 ^ a3 ^ k,
// or just a0 ^ k when the final round bypasses MixColumns.
module mix_byte
   import aes_pkg::*;
(
   input  logic [7:0] a0_i,
   input  logic [7:0] a1_i,
   input  logic [7:0] a2_i,
   input  logic [7:0] a3_i,
   input  logic [7:0] key_i,
   input  logic       bypass_i,
   output logic [7:0] result_o
);

   logic [7:0] mixed;

   always_comb begin
      mixed    = xtime(a0_i) ^ xtime(a1_i) ^ a1_i ^ a2_i ^ a3_i;
      result_o = bypass_i ? (a0_i ^ key_i) : (mixed ^ key_i);
   end

endmodule

// File: rtl/mix_add_key_column.sv
// Column MixColumns + AddRoundKey. Byte-serial (4 cycles/column) by default;
// define MIX_PARALLEL_EN for a single-cycle, four-byte-wide datapath.
module mix_add_key_column
   import aes_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        final_rnd,
   input  logic [31:0] col_in,
   input  logic [31:0] key_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] mix_out
);

   logic [31:0] mixOut_q;
   logic        done_q;

   assign mix_out = mixOut_q;
   assign done    = done_q;

`ifdef MIX_PARALLEL_EN

   logic [31:0] result_d;

   for (genvar g = 0; g < 4; g++) begin : g_byte
      mix_byte u_mix_byte (
         .a0_i     (colByte(col_in, 2'(g))),
         .a1_i     (colByte(col_in, 2'(g + 1))),
         .a2_i     (colByte(col_in, 2'(g + 2))),
         .a3_i     (colByte(col_in, 2'(g + 3))),
         .key_i    (colByte(key_in, 2'(g))),
         .bypass_i (final_rnd),
         .result_o (result_d[31 - 8*g -: 8])
      );
   end

   assign busy = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         mixOut_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= start;
         if (start) begin
            mixOut_q <= result_d;
         end
      end
   end

`else

   mix_state_e  state_q;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [31:0] colWord_q, keyWord_q;
   logic        final_q;
   logic [23:0] shadow_q;
   logic        busy_q;
   logic [7:0]  opA0, opA1, opA2, opA3, opKey, byteResult;

   assign busy = busy_q;

   // Rotating the operands by bcnt lets one byte slice serve all four rows.
   always_comb begin
      bcnt_d = bcnt_q + 2'd1;
      opA0   = colByte(colWord_q, bcnt_q);
      opA1   = colByte(colWord_q, bcnt_q + 2'd1);
      opA2   = colByte(colWord_q, bcnt_q + 2'd2);
      opA3   = colByte(colWord_q, bcnt_q + 2'd3);
      opKey  = colByte(keyWord_q, bcnt_q);
   end

   mix_byte u_mix_byte (
      .a0_i     (opA0),
      .a1_i     (opA1),
      .a2_i     (opA2),
      .a3_i     (opA3),
      .key_i    (opKey),
      .bypass_i (final_q),
      .result_o (byteResult)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bcnt_q    <= 2'd0;
         colWord_q <= '0;
         keyWord_q <= '0;
         final_q   <= 1'b0;
         shadow_q  <= '0;
         mixOut_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  colWord_q <= col_in;
                  keyWord_q <= key_in;
                  final_q   <= final_rnd;
                  bcnt_q    <= 2'd0;
                  busy_q    <= 1'b1;
                  state_q   <= CALC;
               end
            end
            CALC: begin
               bcnt_q <= bcnt_d;
               unique case (bcnt_q)
                  2'd0: shadow_q[23:16] <= byteResult;
                  2'd1: shadow_q[15:8]  <= byteResult;
                  2'd2: shadow_q[7:0]   <= byteResult;
                  default: begin
                     mixOut_q <= {shadow_q, byteResult};
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= IDLE;
                  end
               endcase
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`endif

endmodule

// File: tb/tb_mix_add_key_column.sv
// Self-checking bench for mix_add_key_column: directed vectors, reset cases and
// random columns against a GF(2^8) reference model.
module tb_mix_add_key_column;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        final_rnd;
   logic [31:0] col_in;
   logic [31:0] key_in;
   logic        busy;
   logic        done;
   logic [31:0] mix_out;

`ifdef MIX_PARALLEL_EN
   localparam int LAT_EDGES = 0;
   localparam bit BUSY_WHILE_RUNNING = 1'b0;
`else
   localparam int LAT_EDGES = 4;
   localparam bit BUSY_WHILE_RUNNING = 1'b1;
`endif

   int errors = 0;
   int checks = 0;

   logic [31:0] expQ[$];
   logic [31:0] heldExp = '0;

   mix_add_key_column dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .final_rnd (final_rnd),
      .col_in    (col_in),
      .key_in    (key_in),
      .busy      (busy),
      .done      (done),
      .mix_out   (mix_out)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Shift-and-add GF(2^8) multiply, reduced by x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [31:0] mixModel(input logic [31:0] col, input logic [31:0] key, input logic fin);
      logic [7:0]  a[4];
      logic [7:0]  k[4];
      logic [31:0] res = '0;
      for (int i = 0; i < 4; i++) begin
         a[i] = col[31 - 8*i -: 8];
         k[i] = key[31 - 8*i -: 8];
      end
      for (int i = 0; i < 4; i++) begin
         if (fin)
            res[31 - 8*i -: 8] = a[i] ^ k[i];
         else
            res[31 - 8*i -: 8] = gmul(a[i], 8'd2) ^ gmul(a[(i+1)%4], 8'd3)
                                 ^ a[(i+2)%4] ^ a[(i+3)%4] ^ k[i];
      end
      return res;
   endfunction

   // Every cycle out of reset: a done must match the oldest expected column,
   // and mix_out must otherwise hold the last completed value.
   always @(negedge clk) begin
      if (!reset) begin
         if (done) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
               checkOutput("model_result", mix_out, expQ[0]);
               heldExp = expQ.pop_front();
            end
         end else begin
            checkOutput("mix_out_hold", mix_out, heldExp);
         end
      end
   end

   task automatic waitDone(input int expEdges, input string name);
      int n = 0;
      while (!done && n < 30) begin
         @(posedge clk) #1;
         n++;
      end
      if (!done) begin
         checkOutput({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         checkOutput({name, "_latency"}, 32'(n), 32'(expEdges));
         checkOutput({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
   endtask

   // Called at posedge+1; returns in the done cycle so the next call can
   // re-assert start there for back-to-back operation.
   task automatic applyStimulus(input logic [31:0] col, input logic [31:0] key, input logic fin,
                                input bit hasLit, input logic [31:0] lit, input string name);
      start     = 1'b1;
      col_in    = col;
      key_in    = key;
      final_rnd = fin;
      expQ.push_back(mixModel(col, key, fin));
      @(posedge clk) #1;
      start     = 1'b0;
      col_in    = $urandom;
      key_in    = $urandom;
      final_rnd = 1'($urandom);
      if (LAT_EDGES != 0) checkOutput({name, "_busy"}, {31'd0, busy}, {31'd0, BUSY_WHILE_RUNNING});
      waitDone(LAT_EDGES, name);
      if (hasLit && done) checkOutput({name, "_literal"}, mix_out, lit);
   endtask

   task automatic idleCycles(input int n);
      start = 1'b0;
      repeat (n) @(posedge clk) #1;
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      final_rnd = 1'b0;
      col_in    = '0;
      key_in    = '0;
      repeat (3) @(posedge clk) #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_mix_out", mix_out, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      @(posedge clk) #1;

`ifndef MIX_PARALLEL_EN
      // Reset in the second CALC cycle discards the column; start held high is ignored.
      start  = 1'b1;
      col_in = 32'hdb135345;
      key_in = 32'h0;
      @(posedge clk) #1;
      start = 1'b0;
      @(posedge clk) #1;
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk) #1;
      reset = 1'b0;
      start = 1'b0;
`else
      reset = 1'b1;
      start = 1'b1;
      col_in = 32'hdb135345;
      @(posedge clk) #1;
      reset = 1'b0;
      start = 1'b0;
`endif
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
         checkOutput("midreset_mix_out", mix_out, 32'd0);
      end
      @(posedge clk) #1;

      applyStimulus(32'hdb135345, 32'h00000000, 1'b0, 1'b1, 32'h8e4da1bc, "vecA");
      idleCycles(2);
      applyStimulus(32'hf20a225c, 32'h00000001, 1'b0, 1'b1, 32'h9fdc589c, "vecB");
      idleCycles(1);
      applyStimulus(32'h01234567, 32'hffffffff, 1'b1, 1'b1, 32'hfedcba98, "vecFinal");
      applyStimulus(32'hd4bf5d30, 32'h00000000, 1'b0, 1'b1, 32'h046681e5, "b2b_first");
      applyStimulus(32'h01010101, 32'h00000000, 1'b0, 1'b1, 32'h01010101, "b2b_second");
      idleCycles(2);

`ifndef MIX_PARALLEL_EN
      // A start pulse with a different column mid-CALC must not disturb the result.
      start     = 1'b1;
      col_in    = 32'hdb135345;
      key_in    = 32'h0;
      final_rnd = 1'b0;
      expQ.push_back(mixModel(32'hdb135345, 32'h0, 1'b0));
      @(posedge clk) #1;
      start = 1'b0;
      @(posedge clk) #1;
      start  = 1'b1;
      col_in = 32'hf20a225c;
      @(posedge clk) #1;
      start = 1'b0;
      waitDone(2, "midstart");
      if (done) checkOutput("midstart_literal", mix_out, 32'h8e4da1bc);
      idleCycles(8);
`endif

      for (int i = 0; i < 1000; i++) begin
         applyStimulus($urandom, $urandom, ($urandom_range(0, 7) == 0), 1'b0, 32'h0, "rand");
         if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
      end
      idleCycles(8);
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
